// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall / branch flush control.
// Optional FWD_PERF_CNT_EN adds free-running stall and flush event counters.
module fwd_hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        ex_branch_taken,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic       r_ex_valid;
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  logic [4:0] r_ex_rd;
  logic       r_ex_regwrite;
  logic       r_ex_memread;

  logic       r_mem_valid;
  logic [4:0] r_mem_rd;
  logic       r_mem_regwrite;

  logic       r_wb_valid;
  logic [4:0] r_wb_rd;
  logic       r_wb_regwrite;

  logic       w_mem_writes;
  logic       w_wb_writes;
  logic       w_rs1_dep;
  logic       w_rs2_dep;
  logic       w_load_use;
  logic       w_ex_load;

  // A stage can only be a forwarding source if it really writes a non-x0 register.
  assign w_mem_writes = r_mem_valid & r_mem_regwrite & (r_mem_rd != 5'd0);
  assign w_wb_writes  = r_wb_valid  & r_wb_regwrite  & (r_wb_rd  != 5'd0);

  always_comb begin
    fwd_a = FWD_RF;
    if (w_mem_writes && (r_mem_rd == r_ex_rs1))
      fwd_a = FWD_MEM;
    else if (w_wb_writes && (r_wb_rd == r_ex_rs1))
      fwd_a = FWD_WB;
  end

  always_comb begin
    fwd_b = FWD_RF;
    if (w_mem_writes && (r_mem_rd == r_ex_rs2))
      fwd_b = FWD_MEM;
    else if (w_wb_writes && (r_wb_rd == r_ex_rs2))
      fwd_b = FWD_WB;
  end

  assign w_rs1_dep  = id_uses_rs1 & (id_rs1 == r_ex_rd);
  assign w_rs2_dep  = id_uses_rs2 & (id_rs2 == r_ex_rd);
  assign w_load_use = id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != 5'd0)
                    & (w_rs1_dep | w_rs2_dep);

  // A taken branch squashes the dependent instruction, so it overrides the stall.
  assign stall     = w_load_use & ~ex_branch_taken;
  assign flush     = ex_branch_taken;
  assign w_ex_load = ~stall & ~ex_branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs1       <= '0;
      r_ex_rs2       <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_ex_load) begin
        r_ex_valid    <= id_valid;
        r_ex_rs1      <= id_rs1;
        r_ex_rs2      <= id_rs2;
        r_ex_rd       <= id_rd;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Event counters are not built in this configuration.
`endif

endmodule
